// File: rtl/bmd_pm_drain_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bmd_pm_pkg : shared types and defaults for the BMD PM drain sequencer |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package bmd_pm_pkg;

  localparam int unsigned c_CNT_W = 6;

  typedef enum logic [1:0] {
    PM_IDLE  = 2'd0,
    PM_DRAIN = 2'd1,
    PM_ACK   = 2'd2,
    PM_HOLD  = 2'd3
  } pm_state_e;

  typedef enum logic {
    PM_TGT_PS = 1'b0,
    PM_TGT_TO = 1'b1
  } pm_tgt_e;

endpackage
`default_nettype wire

// File: rtl/bmd_pm_drain_ctrl_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bmd_pm_sat_cnt : saturating up/down counter (holds at 0 and at max)   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module bmd_pm_sat_cnt
  import bmd_pm_pkg::*;
#(
  parameter int unsigned W = c_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] c_MAX = '1;

  logic [W-1:0] r_cnt;

  // Simultaneous inc and dec cancel, so only the exclusive cases move the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !dec && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/bmd_pm_drain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bmd_pm_drain_ctrl : drains outstanding BMD traffic, then acks PM req  |
// | Optional drain timeout: define BMD_PM_DRAIN_TIMEOUT_EN. Revision: 1.0 |
// +----------------------------------------------------------------------+
module bmd_pm_drain_ctrl
  import bmd_pm_pkg::*;
#(
  parameter int          TCQ            = 1,
  parameter int unsigned CNT_W          = c_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_compl,
  input  logic             compl_done,
  input  logic             rd_req_issued,
  input  logic             rd_cpl_last,
  input  logic             cfg_power_state_change_interrupt,
  input  logic             cfg_to_turnoff,
  output logic             cfg_power_state_change_ack,
  output logic             cfg_turnoff_ok,
  output logic             req_hold,
  output logic [CNT_W-1:0] cpl_pending,
  output logic [CNT_W-1:0] rd_pending,
  output logic [1:0]       pm_state,
  output logic             drain_timeout
);

  if ((TIMEOUT_CYCLES < 2) || (TCQ < 0)) begin : g_param_chk
    $error("bmd_pm_drain_ctrl: TIMEOUT_CYCLES must be >= 2 and TCQ >= 0");
  end

  pm_state_e        r_state;
  pm_state_e        w_state_nxt;
  pm_tgt_e          r_tgt;
  pm_tgt_e          w_tgt_nxt;
  logic [CNT_W-1:0] w_cpl_cnt;
  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_trig;
  logic             w_cnt_zero;
  logic             w_drained;
  logic             w_force;
  logic             w_ack;
  logic             w_ok;
  logic             w_hold;

  bmd_pm_sat_cnt #(.W(CNT_W)) u_cpl_cnt (
    .clk (clk),
    .rst (rst),
    .inc (req_compl),
    .dec (compl_done),
    .cnt (w_cpl_cnt)
  );

  bmd_pm_sat_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rd_req_issued),
    .dec (rd_cpl_last),
    .cnt (w_rd_cnt)
  );

  // Level of whichever request launched the current drain.
  assign w_trig     = (r_tgt == PM_TGT_TO) ? cfg_to_turnoff : cfg_power_state_change_interrupt;
  assign w_cnt_zero = (w_cpl_cnt == '0) && (w_rd_cnt == '0);
  assign w_drained  = w_cnt_zero && !req_compl;

`ifdef BMD_PM_DRAIN_TIMEOUT_EN
  localparam int unsigned      c_TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_drain_to;

  assign w_force = (r_to_cnt == c_TO_MAX) && !w_cnt_zero;

  // Timer parks at its terminal value so a late-arriving request cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt   <= '0;
      r_drain_to <= 1'b0;
    end else if ((r_state == PM_IDLE) && (w_state_nxt == PM_DRAIN)) begin
      r_to_cnt   <= '0;
      r_drain_to <= 1'b0;
    end else if (r_state == PM_DRAIN) begin
      if (r_to_cnt != c_TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if ((w_state_nxt == PM_ACK) && w_force) begin
        r_drain_to <= 1'b1;
      end
    end
  end

  assign drain_timeout = r_drain_to;
`else
  assign w_force       = 1'b0;
  assign drain_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PM_IDLE;
      r_tgt   <= PM_TGT_PS;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    case (r_state)
      PM_IDLE: begin
        if (cfg_to_turnoff) begin
          w_state_nxt = PM_DRAIN;
          w_tgt_nxt   = PM_TGT_TO;
        end else if (cfg_power_state_change_interrupt) begin
          w_state_nxt = PM_DRAIN;
          w_tgt_nxt   = PM_TGT_PS;
        end
      end
      PM_DRAIN: begin
        if (!w_trig) begin
          w_state_nxt = PM_IDLE;
        end else if ((r_tgt == PM_TGT_PS) && cfg_to_turnoff) begin
          w_tgt_nxt = PM_TGT_TO;
        end else if (w_drained || w_force) begin
          w_state_nxt = PM_ACK;
        end
      end
      PM_ACK: begin
        w_state_nxt = PM_HOLD;
      end
      PM_HOLD: begin
        if (!w_trig) begin
          w_state_nxt = PM_IDLE;
        end
      end
      default: begin
        w_state_nxt = PM_IDLE;
      end
    endcase
  end

  always_comb begin
    w_ack  = 1'b0;
    w_ok   = 1'b0;
    w_hold = 1'b0;
    case (r_state)
      PM_DRAIN: begin
        w_hold = 1'b1;
      end
      PM_ACK: begin
        w_hold = 1'b1;
        w_ack  = (r_tgt == PM_TGT_PS);
        w_ok   = (r_tgt == PM_TGT_TO);
      end
      PM_HOLD: begin
        w_hold = 1'b1;
        w_ok   = (r_tgt == PM_TGT_TO);
      end
      default: begin
        w_hold = 1'b0;
      end
    endcase
  end

  assign cfg_power_state_change_ack = w_ack;
  assign cfg_turnoff_ok             = w_ok;
  assign req_hold                   = w_hold;
  assign cpl_pending                = w_cpl_cnt;
  assign rd_pending                 = w_rd_cnt;
  assign pm_state                   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bmd_pm_drain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bmd_pm_drain_ctrl : directed scenarios plus random traffic against |
// | a behavioural model of the PM drain sequencer. Revision: 1.0          |
// +----------------------------------------------------------------------+
module tb_bmd_pm_drain_ctrl;

  localparam int CNT_W  = 6;
  localparam int MAXC   = 63;
  localparam int TO_CYC = 16;
`ifdef BMD_PM_DRAIN_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_compl = 1'b0;
  logic             compl_done = 1'b0;
  logic             rd_req_issued = 1'b0;
  logic             rd_cpl_last = 1'b0;
  logic             intr = 1'b0;
  logic             to = 1'b0;
  logic             ack;
  logic             ok;
  logic             hold;
  logic [CNT_W-1:0] cpl;
  logic [CNT_W-1:0] rd;
  logic [1:0]       pms;
  logic             dto;

  int vectors     = 0;
  int miscompares = 0;

  bmd_pm_drain_ctrl #(
    .TCQ            (1),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .req_compl                        (req_compl),
    .compl_done                       (compl_done),
    .rd_req_issued                    (rd_req_issued),
    .rd_cpl_last                      (rd_cpl_last),
    .cfg_power_state_change_interrupt (intr),
    .cfg_to_turnoff                   (to),
    .cfg_power_state_change_ack       (ack),
    .cfg_turnoff_ok                   (ok),
    .req_hold                         (hold),
    .cpl_pending                      (cpl),
    .rd_pending                       (rd),
    .pm_state                         (pms),
    .drain_timeout                    (dto)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 draining, 2 acknowledging, 3 holding.
  int m_cpl, m_rd, m_ph, m_tmr;
  bit m_to, m_dto;

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > MAXC) ? MAXC : v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cpl <= 0; m_rd <= 0; m_ph <= 0; m_tmr <= 0; m_to <= 1'b0; m_dto <= 1'b0;
    end else begin
      m_cpl <= clamp(m_cpl + int'(req_compl) - int'(compl_done));
      m_rd  <= clamp(m_rd + int'(rd_req_issued) - int'(rd_cpl_last));
      case (m_ph)
        0: if (to || intr) begin
             m_ph <= 1; m_to <= to; m_tmr <= 0; m_dto <= 1'b0;
           end
        1: begin
             m_tmr <= m_tmr + 1;
             if (!(m_to ? to : intr)) m_ph <= 0;
             else if (!m_to && to) m_to <= 1'b1;
             else if (m_cpl == 0 && m_rd == 0 && !req_compl) m_ph <= 2;
             else if (TIMEOUT_ON && m_tmr >= TO_CYC - 1 && (m_cpl != 0 || m_rd != 0)) begin
               m_ph <= 2; m_dto <= 1'b1;
             end
           end
        2: m_ph <= 3;
        default: if (!(m_to ? to : intr)) m_ph <= 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    if (pms !== 2'd0) begin miscompares++; $display("FAIL reset_pm_state: got %0d want 0", pms); end
    vectors++;
    if ({ack, ok, hold, dto} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {ack, ok, hold, dto}); end
    vectors++;
    if ({cpl, rd} !== 12'd0) begin miscompares++; $display("FAIL reset_counters: cpl=%0d rd=%0d want 0", cpl, rd); end
    vectors++;
    rst = 1'b0;
    step();
    if (pms !== 2'd0) begin miscompares++; $display("FAIL reset_release: pm_state %0d want 0", pms); end
    vectors++;
  endtask

  task automatic test_idle_ack();
    int acks;
    intr = 1'b1;
    step();
    if ({pms, hold, ack} !== {2'd1, 1'b1, 1'b0}) begin miscompares++; $display("FAIL idle_ack_n1: pm=%0d hold=%b ack=%b want 1/1/0", pms, hold, ack); end
    vectors++;
    step();
    if ({pms, hold, ack} !== {2'd2, 1'b1, 1'b1}) begin miscompares++; $display("FAIL idle_ack_n2: pm=%0d hold=%b ack=%b want 2/1/1", pms, hold, ack); end
    vectors++;
    acks = 0;
    repeat (7) begin step(); acks += int'(ack); end
    if (acks !== 0 || pms !== 2'd3) begin miscompares++; $display("FAIL idle_ack_hold: extra acks=%0d pm=%0d want 0/3", acks, pms); end
    vectors++;
    intr = 1'b0;
    step();
    if ({pms, hold} !== {2'd0, 1'b0}) begin miscompares++; $display("FAIL idle_ack_exit: pm=%0d hold=%b want 0/0", pms, hold); end
    vectors++;
  endtask

  task automatic test_drain_wait();
    int acks;
    req_compl = 1'b1; repeat (3) step(); req_compl = 1'b0;
    intr = 1'b1;
    step();
    if ({cpl, pms} !== {6'd3, 2'd1}) begin miscompares++; $display("FAIL drain_wait_enter: cpl=%0d pm=%0d want 3/1", cpl, pms); end
    vectors++;
    acks = 0;
    repeat (4) begin step(); acks += int'(ack); end
    if (acks !== 0 || pms !== 2'd1) begin miscompares++; $display("FAIL drain_wait_block: acks=%0d pm=%0d want 0/1", acks, pms); end
    vectors++;
    compl_done = 1'b1; repeat (3) step(); compl_done = 1'b0;
    if ({cpl, pms, ack} !== {6'd0, 2'd1, 1'b0}) begin miscompares++; $display("FAIL drain_wait_zero: cpl=%0d pm=%0d ack=%b want 0/1/0", cpl, pms, ack); end
    vectors++;
    step();
    if (ack !== 1'b1) begin miscompares++; $display("FAIL drain_wait_ack: ack=%b want 1", ack); end
    vectors++;
    step(); intr = 1'b0; step();
  endtask

  task automatic test_saturation();
    rd_req_issued = 1'b1; repeat (70) step(); rd_req_issued = 1'b0;
    if (rd !== 6'd63) begin miscompares++; $display("FAIL sat_max: rd=%0d want 63", rd); end
    vectors++;
    rd_req_issued = 1'b1; rd_cpl_last = 1'b1; step(); rd_req_issued = 1'b0;
    if (rd !== 6'd63) begin miscompares++; $display("FAIL sat_incdec_max: rd=%0d want 63", rd); end
    vectors++;
    repeat (30) step();
    if (rd !== 6'd33) begin miscompares++; $display("FAIL sat_down: rd=%0d want 33", rd); end
    vectors++;
    rd_req_issued = 1'b1; step(); rd_req_issued = 1'b0;
    if (rd !== 6'd33) begin miscompares++; $display("FAIL sat_incdec_mid: rd=%0d want 33", rd); end
    vectors++;
    repeat (34) step(); rd_cpl_last = 1'b0;
    if (rd !== 6'd0) begin miscompares++; $display("FAIL sat_min: rd=%0d want 0", rd); end
    vectors++;
  endtask

  task automatic test_promotion_abort();
    int acks;
    acks = 0;
    rd_req_issued = 1'b1; repeat (2) step(); rd_req_issued = 1'b0;
    intr = 1'b1; step(); acks += int'(ack);
    to = 1'b1; step(); acks += int'(ack);
    if ({rd, pms} !== {6'd2, 2'd1}) begin miscompares++; $display("FAIL promo_drain: rd=%0d pm=%0d want 2/1", rd, pms); end
    vectors++;
    rd_cpl_last = 1'b1; repeat (2) begin step(); acks += int'(ack); end rd_cpl_last = 1'b0;
    step(); acks += int'(ack);
    if ({pms, ok} !== {2'd2, 1'b1}) begin miscompares++; $display("FAIL promo_ack: pm=%0d ok=%b want 2/1", pms, ok); end
    vectors++;
    step(); acks += int'(ack);
    if ({pms, ok} !== {2'd3, 1'b1}) begin miscompares++; $display("FAIL promo_hold: pm=%0d ok=%b want 3/1", pms, ok); end
    vectors++;
    intr = 1'b0; to = 1'b0; step(); acks += int'(ack);
    if ({pms, ok, acks} !== {2'd0, 1'b0, 32'd0}) begin miscompares++; $display("FAIL promo_exit: pm=%0d ok=%b acks=%0d want 0/0/0", pms, ok, acks); end
    vectors++;
    acks = 0;
    rd_req_issued = 1'b1; step(); rd_req_issued = 1'b0;
    intr = 1'b1; step(); step(); acks += int'(ack);
    intr = 1'b0; step(); acks += int'(ack);
    repeat (3) begin step(); acks += int'(ack); end
    if ({pms, acks} !== {2'd0, 32'd0}) begin miscompares++; $display("FAIL abort: pm=%0d acks=%0d want 0/0", pms, acks); end
    vectors++;
    rd_cpl_last = 1'b1; step(); rd_cpl_last = 1'b0;
  endtask

  task automatic test_async_reset();
    req_compl = 1'b1; repeat (5) step(); req_compl = 1'b0;
    intr = 1'b1; step();
    if ({cpl, pms} !== {6'd5, 2'd1}) begin miscompares++; $display("FAIL rst_setup: cpl=%0d pm=%0d want 5/1", cpl, pms); end
    vectors++;
    #2 rst = 1'b1;
    #1;
    if ({pms, cpl, rd, ack, ok, hold, dto} !== 18'd0) begin
      miscompares++;
      $display("FAIL rst_async: pm=%0d cpl=%0d rd=%0d ack=%b ok=%b hold=%b dto=%b want all 0", pms, cpl, rd, ack, ok, hold, dto);
    end
    vectors++;
    intr = 1'b0;
    #1 rst = 1'b0;
    step();
    if ({pms, cpl} !== 8'd0) begin miscompares++; $display("FAIL rst_after: pm=%0d cpl=%0d want 0/0", pms, cpl); end
    vectors++;
  endtask

  task automatic test_timeout();
    int k;
    req_compl = 1'b1; step(); req_compl = 1'b0;
    intr = 1'b1; step();
    if (TIMEOUT_ON) begin
      k = 0;
      while (ack !== 1'b1 && k < 40) begin step(); k++; end
      if (k !== TO_CYC || dto !== 1'b1) begin miscompares++; $display("FAIL timeout_ack: cycles=%0d dto=%b want %0d/1", k, dto, TO_CYC); end
      vectors++;
      step();
    end else begin
      k = 0;
      repeat (1000) begin step(); k += int'(ack); end
      if ({k, pms, dto} !== {32'd0, 2'd1, 1'b0}) begin miscompares++; $display("FAIL no_timeout: acks=%0d pm=%0d dto=%b want 0/1/0", k, pms, dto); end
      vectors++;
    end
    intr = 1'b0; step();
    compl_done = 1'b1; step(); compl_done = 1'b0;
    if ({pms, cpl} !== 8'd0) begin miscompares++; $display("FAIL timeout_cleanup: pm=%0d cpl=%0d want 0/0", pms, cpl); end
    vectors++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit fill;
      fill = ((i / 150) % 2) == 0;
      req_compl     = ($urandom_range(0, 99) < (fill ? 25 : 8));
      compl_done    = ($urandom_range(0, 99) < (fill ? 8 : 30));
      rd_req_issued = ($urandom_range(0, 99) < (fill ? 20 : 6));
      rd_cpl_last   = ($urandom_range(0, 99) < (fill ? 6 : 30));
      if ($urandom_range(0, 49) == 0) intr = ~intr;
      if ($urandom_range(0, 89) == 0) to = ~to;
      step();
      if (pms !== 2'(m_ph)) begin miscompares++; $display("FAIL rnd_pm_state[%0d]: got %0d want %0d", i, pms, m_ph); end
      vectors++;
      if (cpl !== 6'(m_cpl)) begin miscompares++; $display("FAIL rnd_cpl[%0d]: got %0d want %0d", i, cpl, m_cpl); end
      vectors++;
      if (rd !== 6'(m_rd)) begin miscompares++; $display("FAIL rnd_rd[%0d]: got %0d want %0d", i, rd, m_rd); end
      vectors++;
      if (ack !== (m_ph == 2 && !m_to)) begin miscompares++; $display("FAIL rnd_ack[%0d]: got %b", i, ack); end
      vectors++;
      if (ok !== (m_ph >= 2 && m_to)) begin miscompares++; $display("FAIL rnd_ok[%0d]: got %b", i, ok); end
      vectors++;
      if (hold !== (m_ph != 0)) begin miscompares++; $display("FAIL rnd_hold[%0d]: got %b", i, hold); end
      vectors++;
      if (dto !== m_dto) begin miscompares++; $display("FAIL rnd_dto[%0d]: got %b want %b", i, dto, m_dto); end
      vectors++;
    end
    {req_compl, compl_done, rd_req_issued, rd_cpl_last, intr, to} = '0;
  endtask

  initial begin
    test_reset();
    test_idle_ack();
    test_drain_wait();
    test_saturation();
    test_promotion_abort();
    test_async_reset();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
